bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Arbitrates the shared PE-to-memory/register bus among NUM_PE bus interface instances.
- Each bus interface raises bus_request; this block picks one owner round-robin and pulses its grant for one cycle.
- It holds ownership until the transaction completes (mem_ackBus, data_ReadyBus or write_doneBus), or until a timeout.
- Sits between the PE bus interfaces and the global memory / register-file side of the CGRA bus.

Parameters:
- NUM_PE, 4, number of requesting PE bus interfaces (2..16).
- TIMEOUT_CYCLES, 64, max cycles in WAIT before forced release (>=2).
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- bus_request  input  NUM_PE  per-PE request, level, bit i = PE i.
- grant  output  NUM_PE  one-hot, one-cycle grant pulse to the winner.
- owner_id  output  clog2(NUM_PE)  index of the current owner; valid while bus_busy=1.
- bus_busy  output  1  high from the GRANT cycle through the end of WAIT.
- mem_ackBus  input  1  global memory read completion.
- data_ReadyBus  input  1  local register read completion.
- write_doneBus  input  1  write / execution_complete accepted (posted completion).
- txn_done  output  1  one-cycle pulse when the owner's transaction completes normally.
- timeout_err  output  1  one-cycle pulse on forced release.
- err_sticky  output  1  set by timeout_err, cleared only by reset.

Behaviour:
- Reset (reset=0 at posedge):
  - FSM goes to IDLE; rr_ptr=0; counter=0.
  - grant=0, owner_id=0, bus_busy=0, txn_done=0, timeout_err=0, err_sticky=0.
  - Reset mid-transaction drops ownership immediately with no txn_done pulse.
- Registered outputs; FSM states are IDLE, GRANT, WAIT, RELEASE.
- IDLE:
  - If any bus_request bit is set, pick a winner: the first set bit scanning upward (with wrap) from rr_ptr.
  - Register owner_id=winner and go to GRANT. Request-to-grant latency is 1 cycle.
- GRANT (1 cycle):
  - grant[owner_id]=1, all other grant bits 0.
  - bus_busy=1; counter cleared; next state WAIT.
- WAIT:
  - bus_busy=1; grant=0.
  - Completion = mem_ackBus | data_ReadyBus | write_doneBus.
  - On completion: next cycle txn_done=1, state RELEASE.
  - Completion inputs are ignored outside WAIT.
  - Completion and timeout in the same cycle: completion wins, no timeout_err.
  - Otherwise counter increments. When counter == TIMEOUT_CYCLES-1 without completion: timeout_err=1, err_sticky=1, state RELEASE.
- RELEASE (1 cycle):
  - bus_busy=0; rr_ptr = (owner_id+1) mod NUM_PE; next state IDLE.
  - The mandatory dead cycle lets the bus interface clear its active flag and bus_request before re-arbitration.
- Minimum grant-to-grant spacing is 4 cycles (GRANT, WAIT>=1, RELEASE, IDLE).
- Arbitration rules:
  - A requester dropping bus_request while in WAIT does not end ownership; only completion or timeout does.
  - A single persistent requester is re-granted every cycle through the loop; no starvation, since each other requester waits at most NUM_PE-1 grants.
  - rr_ptr wrap: NUM_PE-1 -> 0.
  - Requests arriving during GRANT/WAIT/RELEASE are held off and considered at the next IDLE.
- Invariants:
  - grant is never multi-hot.
  - grant=1 only in GRANT.
  - txn_done and timeout_err are never high together.

Decomposition:
- Shared package bus_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_WAIT=2'd2, ST_RELEASE=2'd3;
  - OWNER_W = clog2(NUM_PE) helper;
  - default TIMEOUT_CYCLES.
- One combinational sub-module, rr_priority_pick (NUM_PE): inputs req vector and ptr; outputs winner index and a valid bit. It is reused later by the CGRA controller.

Test Plan:
- Single request: bus_request=4'b0100 from IDLE -> grant=4'b0100 one cycle later, owner_id=2; mem_ackBus at WAIT cycle 3 -> txn_done pulse next cycle, bus_busy low in RELEASE.
- Round-robin fairness: bus_request=4'b1111 held for 8 grants, each completed by data_ReadyBus -> grant order PE0,1,2,3,0,1,2,3 with no multi-hot grant.
- Wrap and skip: rr_ptr=3, bus_request=4'b0011 -> winner PE0, then PE1; with bus_request=4'b1000 after PE3 -> PE3 re-granted, rr_ptr becomes 0.
- Timeout: grant PE1, no completion for 64 cycles -> timeout_err pulse at WAIT cycle 63, err_sticky=1, PE2 (requesting) granted 2 cycles later; no txn_done.
- Simultaneous events: write_doneBus on exactly the timeout cycle -> txn_done=1, timeout_err=0, err_sticky unchanged; completion pulses in IDLE -> ignored.
- Reset mid-op: reset=0 during WAIT with owner PE3 -> next cycle all outputs 0, FSM IDLE, rr_ptr=0; after release with bus_request=4'b1010 -> PE1 granted first.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the PE bus arbiter and its round-robin picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arbState_t;

  localparam int DEFAULT_TIMEOUT = 64;

  // Width of an owner index; never below 1 bit.
  function automatic int ownerW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_pick.sv
// Round-robin priority picker: first set request at or after ptr, with wrap.
// Purely combinational; also used by the CGRA controller.
module rr_priority_pick
  import bus_arb_pkg::*;
#(
  parameter int  NUM_PE  = 4,
  localparam int OWNER_W = ownerW(NUM_PE)
) (
  input  logic [NUM_PE-1:0]  req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [OWNER_W-1:0] winner,
  output logic               valid
);

  // Scan offsets from farthest to nearest so the nearest set bit is the last write.
  always_comb begin
    logic [OWNER_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      idx = OWNER_W'((int'(ptr) + i) % NUM_PE);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration of the shared PE-to-memory/register bus.
// One owner at a time; ownership lasts from a one-cycle grant pulse until
// a completion strobe or a WAIT timeout, followed by a dead RELEASE cycle.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int  NUM_PE         = 4,
  parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int  CNT_W          = 8,
  localparam int OWNER_W        = ownerW(NUM_PE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_PE-1:0]  bus_request,
  output logic [NUM_PE-1:0]  grant,
  output logic [OWNER_W-1:0] owner_id,
  output logic               bus_busy,
  input  logic               mem_ackBus,
  input  logic               data_ReadyBus,
  input  logic               write_doneBus,
  output logic               txn_done,
  output logic               timeout_err,
  output logic               err_sticky
);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_PE-1:0]  GRANT_ONE = NUM_PE'(1);
  localparam logic [OWNER_W-1:0] LAST_PE   = OWNER_W'(NUM_PE - 1);

  arbState_t          state, stateNext;
  logic [OWNER_W-1:0] rrPtr, rrPtrNext;
  logic [OWNER_W-1:0] ownerNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [NUM_PE-1:0]  grantNext;
  logic               busyNext, doneNext, toutNext, stickyNext;
  logic [OWNER_W-1:0] pickWinner;
  logic               pickValid;
  logic               complete;

  assign complete = mem_ackBus | data_ReadyBus | write_doneBus;

  rr_priority_pick #(.NUM_PE(NUM_PE)) uPick (
    .req    (bus_request),
    .ptr    (rrPtr),
    .winner (pickWinner),
    .valid  (pickValid)
  );

  // Next-state logic; outputs are computed for the upcoming state and registered.
  always_comb begin
    stateNext  = state;
    rrPtrNext  = rrPtr;
    ownerNext  = owner_id;
    cntNext    = cnt;
    grantNext  = '0;
    busyNext   = 1'b0;
    doneNext   = 1'b0;
    toutNext   = 1'b0;
    stickyNext = err_sticky;
    unique case (state)
      ST_IDLE: begin
        if (pickValid) begin
          ownerNext = pickWinner;
          grantNext = GRANT_ONE << pickWinner;
          busyNext  = 1'b1;
          stateNext = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cntNext   = '0;
        busyNext  = 1'b1;
        stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion outranks a timeout landing on the same cycle.
        if (complete) begin
          doneNext  = 1'b1;
          stateNext = ST_RELEASE;
        end else if (cnt == CNT_LAST) begin
          toutNext   = 1'b1;
          stickyNext = 1'b1;
          stateNext  = ST_RELEASE;
        end else begin
          cntNext  = cnt + CNT_W'(1);
          busyNext = 1'b1;
        end
      end
      ST_RELEASE: begin
        // Dead cycle: requester drops its request before the next pick.
        rrPtrNext = (owner_id == LAST_PE) ? '0 : owner_id + OWNER_W'(1);
        stateNext = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rrPtr       <= '0;
      owner_id    <= '0;
      cnt         <= '0;
      grant       <= '0;
      bus_busy    <= 1'b0;
      txn_done    <= 1'b0;
      timeout_err <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      state       <= stateNext;
      rrPtr       <= rrPtrNext;
      owner_id    <= ownerNext;
      cnt         <= cntNext;
      grant       <= grantNext;
      bus_busy    <= busyNext;
      txn_done    <= doneNext;
      timeout_err <= toutNext;
      err_sticky  <= stickyNext;
    end
  end

endmodule
